rcp_word_tracker: RTL
=====================

// Module: rcp_word_tracker
// PURPOSE
// Stage directly upstream of the RCP header parser in the rcp_router user data path.
// Tracks each NetFPGA packet word by word: module-header words first, then Ethernet/IP/RCP data words.
// Forwards the stream through a single register stage.
// Emits one-cycle strobes (word_RCP_FIRST/THIRD/RTT/FRATE) aligned with the registered word, so the parser captures fields on the strobe.
// PARAMETERS
// DATA_WIDTH     64     data bus width
// CTRL_WIDTH     8      ctrl bus width (DATA_WIDTH/8)
// IOQ_STAGE_NUM  8'hFF  ctrl value marking the IO-queue module header (dst port/lengths)
// WORD_THIRD     3      data-word index carrying IP proto in [7:0]
// WORD_RTT       5      data-word index carrying RCP RTT [47:32] / proto [31:24]
// WORD_FRATE     6      data-word index carrying RCP forward rate [47:16]
// PORTS
// clk              in   1    clock
// reset            in   1    synchronous, active-high reset
// in_data          in   DW   input word
// in_ctrl          in   CW   input ctrl
// in_wr            in   1    input word valid
// in_rdy           out  1    ready to upstream; = out_rdy (combinational)
// out_data         out  DW   registered copy of in_data
// out_ctrl         out  CW   registered copy of in_ctrl
// out_wr           out  1    registered in_wr
// out_rdy          in   1    downstream ready
// word_RCP_FIRST   out  1    out_data is the IOQ module header
// word_RCP_THIRD   out  1    out_data is data word WORD_THIRD
// word_RCP_RTT     out  1    out_data is data word WORD_RTT
// word_RCP_FRATE   out  1    out_data is data word WORD_FRATE
// BEHAVIOUR
// - Reset: out_data=0, out_ctrl=0, out_wr=0, all word_* =0, state=MODULE_HDRS, word_cnt=0.
// - Pipeline: every cycle out_data<=in_data, out_ctrl<=in_ctrl, out_wr<=in_wr (latency 1).
//   No internal buffering; upstream writes only while in_rdy; downstream FIFO absorbs the in-flight word.
// - Strobes register in the same cycle as out_*; they are high only with out_wr=1, for exactly one cycle.
// - State machine, advances only on cycles with in_wr=1:
//   MODULE_HDRS:
//     - in_ctrl==IOQ_STAGE_NUM  -> word_RCP_FIRST=1; stay.
//     - any other in_ctrl!=0    -> no strobe; stay.
//     - in_ctrl==0              -> word_cnt<=1; go to IN_PACKET.
//       This is data word 1; no strobe fires because WORD_* >=2.
//   IN_PACKET:
//     - in_ctrl==0              -> word_cnt<=word_cnt+1 (4-bit, saturates at 15).
//       Strobe fires when the new count equals WORD_THIRD / WORD_RTT / WORD_FRATE.
//     - in_ctrl!=0 (EOP word)   -> counts as a data word for strobe purposes.
//       Then go to MODULE_HDRS and clear word_cnt.
// - Short packets: if EOP arrives before index N, the strobe for N never fires. No carry-over to the next packet.
// - EOP on the same word as a strobe index: the strobe still fires.
// - More than one IOQ header in a packet: FIRST fires on each.
// - Back-to-back packets: the header word right after EOP is handled in MODULE_HDRS with no idle cycle.
// - in_wr=0: state and count hold; strobes and out_wr drop to 0 next cycle.
// - Reset mid-packet: state/count cleared, so the remainder of that packet is mis-tracked.
//   A reset is only issued with the datapath drained.
// TESTING
// - Reset: assert reset 2 cycles with in_wr=1 -> out_wr=0, all strobes 0, next cycle after release tracks normally.
// - Nominal packet: IOQ hdr(ctrl FF) + 8 data words (last ctrl 0x01), contiguous in_wr.
//   -> FIRST at out cycle 1, THIRD at 4, RTT at 6, FRATE at 7.
//   -> out_data equals in_data delayed 1 cycle.
// - Gaps: same packet with in_wr low for 3 cycles between words 4 and 5 -> RTT/FRATE still on data words 5/6, none during gaps.
// - Short packet: hdr + 4 words (EOP ctrl 0x80 on word 4) -> FIRST and THIRD only.
//   Next packet's strobes correct (RTT on its word 5).
// - Back-to-back: two packets with no idle; second hdr immediately after EOP -> FIRST fires for both; counts restart at 1.
// - Backpressure: out_rdy=0 for 5 cycles mid-packet -> in_rdy=0 same cycles, no word lost or duplicated, strobe positions unchanged.

Source files
------------

// File: rtl/rcp_word_tracker.sv
// Single-register-stage pass-through that counts packet words and raises
// one-cycle strobes, aligned with out_data, on the words the RCP parser samples.
module rcp_word_tracker #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = 'hFF,
  parameter int WORD_THIRD = 3,
  parameter int WORD_RTT   = 5,
  parameter int WORD_FRATE = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  word_RCP_FIRST,
  output logic                  word_RCP_THIRD,
  output logic                  word_RCP_RTT,
  output logic                  word_RCP_FRATE
);

  // state       | meaning
  // MODULE_HDRS | between packets or inside the module-header words
  // IN_PACKET   | inside the data words; word_cnt is the last data-word index
  typedef enum logic {MODULE_HDRS, IN_PACKET} state_t;

  localparam logic [3:0] IDX_THIRD = 4'(WORD_THIRD);
  localparam logic [3:0] IDX_RTT   = 4'(WORD_RTT);
  localparam logic [3:0] IDX_FRATE = 4'(WORD_FRATE);

  state_t     state;
  logic [3:0] word_cnt;
  logic [3:0] next_cnt;

  assign in_rdy = out_rdy;

  // Saturate so very long packets never wrap back onto a strobe index.
  always_comb begin
    next_cnt = (word_cnt == 4'hF) ? 4'hF : word_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data       <= '0;
      out_ctrl       <= '0;
      out_wr         <= 1'b0;
      word_RCP_FIRST <= 1'b0;
      word_RCP_THIRD <= 1'b0;
      word_RCP_RTT   <= 1'b0;
      word_RCP_FRATE <= 1'b0;
      state          <= MODULE_HDRS;
      word_cnt       <= 4'd0;
    end else begin
      out_data       <= in_data;
      out_ctrl       <= in_ctrl;
      out_wr         <= in_wr;
      word_RCP_FIRST <= 1'b0;
      word_RCP_THIRD <= 1'b0;
      word_RCP_RTT   <= 1'b0;
      word_RCP_FRATE <= 1'b0;
      if (in_wr) begin
        case (state)
          MODULE_HDRS: begin
            if (in_ctrl == IOQ_STAGE_NUM) begin
              word_RCP_FIRST <= 1'b1;
            end else if (in_ctrl == '0) begin
              word_cnt <= 4'd1;
              state    <= IN_PACKET;
            end
          end
          IN_PACKET: begin
            // The EOP word is still a data word, so it may carry a strobe.
            word_RCP_THIRD <= (next_cnt == IDX_THIRD);
            word_RCP_RTT   <= (next_cnt == IDX_RTT);
            word_RCP_FRATE <= (next_cnt == IDX_FRATE);
            if (in_ctrl == '0) begin
              word_cnt <= next_cnt;
            end else begin
              word_cnt <= 4'd0;
              state    <= MODULE_HDRS;
            end
          end
          default: begin
            word_cnt <= 4'd0;
            state    <= MODULE_HDRS;
          end
        endcase
      end
    end
  end

endmodule
